// File: rtl/dop_pkg.sv
// dop_pkg -- shared constants and state types for the DoP (DSD over PCM) scheduler.
//   MARKER_A / MARKER_B : the two alternating DoP marker bytes
//   SILENCE_BYTE        : DSD idle pattern byte
//   mk_state_e          : marker-lock FSM states
//   sc_state_e          : output-scheduler FSM states
package dop_pkg;

  localparam logic [7:0] MARKER_A     = 8'h05;
  localparam logic [7:0] MARKER_B     = 8'hFA;
  localparam logic [7:0] SILENCE_BYTE = 8'h69;

  typedef enum logic {MK_SEARCH, MK_LOCKED} mk_state_e;
  typedef enum logic {SC_PRIME, SC_RUN} sc_state_e;

  // Both channels must carry the same marker, and it must be one of the two DoP values.
  function automatic logic is_good_marker(input logic [7:0] l_mk, input logic [7:0] r_mk);
    return (l_mk == r_mk) && ((l_mk == MARKER_A) || (l_mk == MARKER_B));
  endfunction

  function automatic logic [7:0] other_marker(input logic [7:0] mk);
    return (mk == MARKER_A) ? MARKER_B : MARKER_A;
  endfunction

endpackage

// File: rtl/dop_fifo.sv
// dop_fifo -- synchronous show-ahead FIFO with flush.
//   clk, rst            : clock, asynchronous active-high reset
//   i_flush             : empties the FIFO; overrides a same-cycle write or read
//   i_wr / i_wdata      : write request and data (ignored while full)
//   i_rd                : pop request (ignored while empty)
//   o_rdata             : head entry, valid while o_empty is low
//   o_full/o_empty      : status flags
//   o_count             : current occupancy
module dop_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_flush,
  input  logic                   i_wr,
  input  logic [W-1:0]           i_wdata,
  input  logic                   i_rd,
  output logic [W-1:0]           o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_wr;
  logic          w_rd;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];

  // Fullness is judged on the registered count, so a same-cycle pop never frees room for a write.
  assign w_wr = i_wr & ~o_full  & ~i_flush;
  assign w_rd = i_rd & ~o_empty & ~i_flush;

  // NOTE: storage is deliberately not reset; pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= i_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      if (w_wr && !w_rd)      r_count <= r_count + 1'b1;
      else if (!w_wr && w_rd) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/dop_sched.sv
// dop_sched -- DoP marker lock and fixed-slot word scheduler for a DSD serializer.
//   bclk, rst                : bit clock, asynchronous active-high reset
//   pcm_valid_i/pcm_ready_o  : PCM sample-pair handshake
//   pcm_ldata_i/pcm_rdata_i  : [23:16] DoP marker, [15:0] DSD payload
//   tx_valid_o               : one-cycle load pulse, once every SLOT cycles
//   tx_ldata_o/tx_rdata_o    : word to load (DSD silence when nothing to play)
//   dop_lock_o               : high while the marker stream is locked
//   underrun_o, marker_err_o : one-cycle event pulses
module dop_sched
  import dop_pkg::*;
#(
  parameter int DW         = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int LOCK_CNT   = 4,
  parameter int SLOT       = 64
) (
  input  logic          bclk,
  input  logic          rst,
  input  logic          pcm_valid_i,
  output logic          pcm_ready_o,
  input  logic [23:0]   pcm_ldata_i,
  input  logic [23:0]   pcm_rdata_i,
  output logic          tx_valid_o,
  output logic [DW-1:0] tx_ldata_o,
  output logic [DW-1:0] tx_rdata_o,
  output logic          dop_lock_o,
  output logic          underrun_o,
  output logic          marker_err_o
);

  localparam int               CW         = $clog2(LOCK_CNT + 1);
  localparam logic [CW-1:0]    LOCK_TGT   = CW'(LOCK_CNT);
  localparam int               SW         = $clog2(SLOT);
  localparam logic [SW-1:0]    SLOT_LAST  = SW'(SLOT - 1);
  localparam int               FCW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DW-1:0]    SILENCE    = {(DW/8){SILENCE_BYTE}};
  localparam logic [2*DW-1:0]  SILENCE_LR = {SILENCE, SILENCE};

  mk_state_e       r_mk_state, w_mk_next;
  sc_state_e       r_sc_state, w_sc_next;
  logic [7:0]      r_expect, w_expect_next;
  logic [CW-1:0]   r_run_cnt, w_run_cnt_next;
  logic            r_marker_err, w_marker_err_next;
  logic [SW-1:0]   r_slot;
  logic [2*DW-1:0] r_hold, w_hold_next;

  logic            w_accept, w_good, w_fifo_wr, w_flush, w_pop;
  logic            w_slot_pulse, w_underrun;
  logic            w_full, w_empty;
  logic [FCW-1:0]  w_count;
  logic [2*DW-1:0] w_head, w_word;
  logic [7:0]      w_marker;

  assign w_marker     = pcm_ldata_i[23:16];
  assign w_good       = is_good_marker(pcm_ldata_i[23:16], pcm_rdata_i[23:16]);
  assign pcm_ready_o  = (r_mk_state == MK_SEARCH) | ~w_full;
  assign w_accept     = pcm_valid_i & pcm_ready_o;
  assign dop_lock_o   = (r_mk_state == MK_LOCKED);
  assign marker_err_o = r_marker_err;
  assign w_slot_pulse = (r_slot == SLOT_LAST);
  assign tx_valid_o   = w_slot_pulse;
  assign underrun_o   = w_underrun;

  // The word is valid during the pulse itself; between pulses the last loaded word is held.
  assign tx_ldata_o = w_slot_pulse ? w_word[2*DW-1:DW] : r_hold[2*DW-1:DW];
  assign tx_rdata_o = w_slot_pulse ? w_word[DW-1:0]    : r_hold[DW-1:0];

  dop_fifo #(.W(2*DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (bclk),
    .rst     (rst),
    .i_flush (w_flush),
    .i_wr    (w_fifo_wr),
    .i_wdata ({DW'(pcm_ldata_i[15:0]), DW'(pcm_rdata_i[15:0])}),
    .i_rd    (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Marker lock FSM.
  // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
  always_comb begin
    w_mk_next         = r_mk_state;
    w_expect_next     = r_expect;
    w_run_cnt_next    = r_run_cnt;
    w_marker_err_next = 1'b0;
    w_fifo_wr         = 1'b0;
    w_flush           = 1'b0;
    if (w_accept) begin
      case (r_mk_state)
        MK_SEARCH: begin
          // A zero count means no run in progress: any good marker starts one.
          if (w_good && ((r_run_cnt == '0) || (w_marker == r_expect))) begin
            w_expect_next  = other_marker(w_marker);
            w_run_cnt_next = r_run_cnt + 1'b1;
            if (r_run_cnt + 1'b1 == LOCK_TGT) begin
              w_mk_next = MK_LOCKED;
              w_fifo_wr = 1'b1;
            end
          end else begin
            w_run_cnt_next    = '0;
            w_marker_err_next = 1'b1;
          end
        end
        MK_LOCKED: begin
          if (w_good && (w_marker == r_expect)) begin
            w_expect_next = other_marker(w_marker);
            w_fifo_wr     = 1'b1;
          end else begin
            w_mk_next         = MK_SEARCH;
            w_run_cnt_next    = '0;
            w_marker_err_next = 1'b1;
            w_flush           = 1'b1;
          end
        end
        default: w_mk_next = MK_SEARCH;
      endcase
    end
  end

  // Output scheduler FSM.
  always_comb begin
    w_sc_next  = r_sc_state;
    w_pop      = 1'b0;
    w_underrun = 1'b0;
    w_word     = SILENCE_LR;
    case (r_sc_state)
      SC_PRIME: begin
        // Start only with two words banked so the next slot is already covered.
        if (w_slot_pulse && dop_lock_o && !w_flush && (w_count >= FCW'(2))) begin
          w_pop     = 1'b1;
          w_word    = w_head;
          w_sc_next = SC_RUN;
        end
      end
      SC_RUN: begin
        if (!dop_lock_o) begin
          w_sc_next = SC_PRIME;
        end else if (w_slot_pulse) begin
          if (w_flush) begin
            w_sc_next = SC_PRIME;
          end else if (w_empty) begin
            w_underrun = 1'b1;
            w_sc_next  = SC_PRIME;
          end else begin
            w_pop  = 1'b1;
            w_word = w_head;
          end
        end
      end
      default: w_sc_next = SC_PRIME;
    endcase
    if (w_sc_next == SC_PRIME)  w_hold_next = SILENCE_LR;
    else if (w_slot_pulse)      w_hold_next = w_word;
    else                        w_hold_next = r_hold;
  end

  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      r_mk_state   <= MK_SEARCH;
      r_sc_state   <= SC_PRIME;
      r_expect     <= MARKER_A;
      r_run_cnt    <= '0;
      r_marker_err <= 1'b0;
      r_slot       <= '0;
      r_hold       <= SILENCE_LR;
    end else begin
      r_mk_state   <= w_mk_next;
      r_sc_state   <= w_sc_next;
      r_expect     <= w_expect_next;
      r_run_cnt    <= w_run_cnt_next;
      r_marker_err <= w_marker_err_next;
      r_slot       <= w_slot_pulse ? '0 : r_slot + 1'b1;
      r_hold       <= w_hold_next;
    end
  end

endmodule

// File: tb/tb_dop_sched.sv
// tb_dop_sched -- directed self-checking bench for dop_sched (default parameters).
module tb_dop_sched;
  import dop_pkg::*;

  logic        bclk;
  logic        rst;
  logic        pcm_valid_i;
  logic        pcm_ready_o;
  logic [23:0] pcm_ldata_i;
  logic [23:0] pcm_rdata_i;
  logic        tx_valid_o;
  logic [15:0] tx_ldata_o;
  logic [15:0] tx_rdata_o;
  logic        dop_lock_o;
  logic        underrun_o;
  logic        marker_err_o;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  dop_sched dut (
    .bclk         (bclk),
    .rst          (rst),
    .pcm_valid_i  (pcm_valid_i),
    .pcm_ready_o  (pcm_ready_o),
    .pcm_ldata_i  (pcm_ldata_i),
    .pcm_rdata_i  (pcm_rdata_i),
    .tx_valid_o   (tx_valid_o),
    .tx_ldata_o   (tx_ldata_o),
    .tx_rdata_o   (tx_rdata_o),
    .dop_lock_o   (dop_lock_o),
    .underrun_o   (underrun_o),
    .marker_err_o (marker_err_o)
  );

  initial bclk = 1'b0;
  always #5 bclk = ~bclk;
  always @(posedge bclk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge bclk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the sample.
  task automatic send(input logic [7:0] lm, input logic [7:0] rm,
                      input logic [15:0] lp, input logic [15:0] rp);
    bit   done;
    logic acc;
    done        = 0;
    pcm_ldata_i = {lm, lp};
    pcm_rdata_i = {rm, rp};
    pcm_valid_i = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      acc = pcm_ready_o;
      step();
      if (acc) done = 1;
    end
    pcm_valid_i = 1'b0;
    check("send_accepted", {31'b0, done}, 32'd1);
  endtask

  // Returns just after the edge that ends the load pulse.
  task automatic wait_pulse(output logic [15:0] l, output logic [15:0] r,
                            output logic u, output int t);
    bit seen;
    seen = 0;
    l = '0; r = '0; u = 1'b0; t = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      if (tx_valid_o) begin
        seen = 1;
        l = tx_ldata_o;
        r = tx_rdata_o;
        u = underrun_o;
        t = cyc;
      end
      step();
    end
    check("pulse_seen", {31'b0, seen}, 32'd1);
  endtask

  initial begin
    logic [15:0] l, r;
    logic        u, rdy_at_pulse;
    int          t1, t2, first_n;
    bit          seen, stray;

    rst         = 1'b1;
    pcm_valid_i = 1'b0;
    pcm_ldata_i = '0;
    pcm_rdata_i = '0;
    repeat (3) step();

    // Reset values.
    check("rst_tx_valid",   {31'b0, tx_valid_o},   32'd0);
    check("rst_underrun",   {31'b0, underrun_o},   32'd0);
    check("rst_marker_err", {31'b0, marker_err_o}, 32'd0);
    check("rst_lock",       {31'b0, dop_lock_o},   32'd0);
    check("rst_ready",      {31'b0, pcm_ready_o},  32'd1);
    check("rst_tx_l",       {16'b0, tx_ldata_o},   32'h6969);
    check("rst_tx_r",       {16'b0, tx_rdata_o},   32'h6969);
    rst = 1'b0;

    // SEARCH: L/R markers disagree -> error pulse, nothing locks.
    send(8'h05, 8'hFA, 16'h0000, 16'h0000);
    check("search_err_pulse", {31'b0, marker_err_o}, 32'd1);
    check("search_err_lock",  {31'b0, dop_lock_o},   32'd0);

    // Lock sequence 05,FA,05,FA; lock rises on the 4th acceptance.
    send(8'h05, 8'h05, 16'h1111, 16'h1111);
    check("search_err_clear", {31'b0, marker_err_o}, 32'd0);
    send(8'hFA, 8'hFA, 16'h2222, 16'h2222);
    send(8'h05, 8'h05, 16'h3333, 16'h3333);
    check("lock_after_3", {31'b0, dop_lock_o}, 32'd0);
    send(8'hFA, 8'hFA, 16'h1234, 16'hABCD);
    check("lock_after_4", {31'b0, dop_lock_o}, 32'd1);
    check("fifo_cnt_lock", 32'(dut.u_fifo.o_count), 32'd1);
    send(8'h05, 8'h05, 16'h5678, 16'hEF01);
    check("fifo_cnt_2", 32'(dut.u_fifo.o_count), 32'd2);

    // Words come out one slot apart.
    wait_pulse(l, r, u, t1);
    check("w1_l", {16'b0, l}, 32'h1234);
    check("w1_r", {16'b0, r}, 32'hABCD);
    check("w1_underrun", {31'b0, u}, 32'd0);
    check("w1_hold_l", {16'b0, tx_ldata_o}, 32'h1234);
    check("w1_valid_low", {31'b0, tx_valid_o}, 32'd0);
    wait_pulse(l, r, u, t2);
    check("w2_l", {16'b0, l}, 32'h5678);
    check("w2_r", {16'b0, r}, 32'hEF01);
    check("w2_spacing", t2 - t1, 32'd64);

    // Feed stopped: silence with a single underrun pulse, back to PRIME.
    wait_pulse(l, r, u, t1);
    check("ur_l", {16'b0, l}, 32'h6969);
    check("ur_r", {16'b0, r}, 32'h6969);
    check("ur_pulse", {31'b0, u}, 32'd1);
    check("ur_pulse_once", {31'b0, underrun_o}, 32'd0);
    check("ur_prime", 32'(dut.r_sc_state), 32'(SC_PRIME));
    check("ur_still_locked", {31'b0, dop_lock_o}, 32'd1);

    // Fill the FIFO (expected marker is FA), then hold one more sample.
    send(8'hFA, 8'hFA, 16'hA001, 16'hB001);
    send(8'h05, 8'h05, 16'hA002, 16'hB002);
    send(8'hFA, 8'hFA, 16'hA003, 16'hB003);
    send(8'h05, 8'h05, 16'hA004, 16'hB004);
    check("full_cnt", 32'(dut.u_fifo.o_count), 32'd4);
    pcm_ldata_i = {8'hFA, 16'hC001};
    pcm_rdata_i = {8'hFA, 16'hD001};
    pcm_valid_i = 1'b1;
    check("full_ready", {31'b0, pcm_ready_o}, 32'd0);
    seen = 0; stray = 0; rdy_at_pulse = 1'b1;
    for (int n = 0; n < 200 && !seen; n++) begin
      if (tx_valid_o) begin
        seen = 1;
        l = tx_ldata_o;
        r = tx_rdata_o;
        rdy_at_pulse = pcm_ready_o;
      end else if (pcm_ready_o) begin
        stray = 1;
      end
      step();
    end
    check("full_pulse_seen", {31'b0, seen}, 32'd1);
    check("full_no_stray_ready", {31'b0, stray}, 32'd0);
    check("full_ready_at_pop", {31'b0, rdy_at_pulse}, 32'd0);
    check("p1_l", {16'b0, l}, 32'hA001);
    check("p1_r", {16'b0, r}, 32'hB001);
    check("ready_after_pop", {31'b0, pcm_ready_o}, 32'd1);
    step();
    pcm_valid_i = 1'b0;
    check("refill_cnt", 32'(dut.u_fifo.o_count), 32'd4);

    wait_pulse(l, r, u, t1);
    check("p2_l", {16'b0, l}, 32'hA002);
    send(8'h05, 8'h05, 16'hE001, 16'hF001);
    wait_pulse(l, r, u, t1);
    check("p3_l", {16'b0, l}, 32'hA003);
    check("p3_r", {16'b0, r}, 32'hB003);
    check("pre_err_cnt", 32'(dut.u_fifo.o_count), 32'd3);

    // Wrong marker (05 where FA expected) while locked.
    send(8'h05, 8'h05, 16'hDEAD, 16'hBEEF);
    check("err_pulse", {31'b0, marker_err_o}, 32'd1);
    check("err_lock", {31'b0, dop_lock_o}, 32'd0);
    check("err_flush", 32'(dut.u_fifo.o_count), 32'd0);
    step();
    check("err_pulse_once", {31'b0, marker_err_o}, 32'd0);
    check("err_hold_silence", {16'b0, tx_ldata_o}, 32'h6969);
    check("err_prime", 32'(dut.r_sc_state), 32'(SC_PRIME));
    wait_pulse(l, r, u, t1);
    check("err_word_l", {16'b0, l}, 32'h6969);
    check("err_word_r", {16'b0, r}, 32'h6969);
    check("err_no_underrun", {31'b0, u}, 32'd0);

    // Relock, reach RUN, then reset at slot count 30.
    send(8'h05, 8'h05, 16'h0001, 16'h0001);
    send(8'hFA, 8'hFA, 16'h0002, 16'h0002);
    send(8'h05, 8'h05, 16'h0003, 16'h0003);
    send(8'hFA, 8'hFA, 16'h4444, 16'h5555);
    send(8'h05, 8'h05, 16'h6666, 16'h7777);
    wait_pulse(l, r, u, t1);
    check("relock_word", {16'b0, l}, 32'h4444);
    check("relock_run", 32'(dut.r_sc_state), 32'(SC_RUN));
    repeat (30) step();
    check("slot_30", 32'(dut.r_slot), 32'd30);
    rst = 1'b1;
    #1;
    check("mrst_tx_valid",   {31'b0, tx_valid_o},   32'd0);
    check("mrst_underrun",   {31'b0, underrun_o},   32'd0);
    check("mrst_marker_err", {31'b0, marker_err_o}, 32'd0);
    check("mrst_lock",       {31'b0, dop_lock_o},   32'd0);
    check("mrst_ready",      {31'b0, pcm_ready_o},  32'd1);
    check("mrst_tx_l",       {16'b0, tx_ldata_o},   32'h6969);
    check("mrst_tx_r",       {16'b0, tx_rdata_o},   32'h6969);
    check("mrst_fifo_empty", 32'(dut.u_fifo.o_count), 32'd0);
    repeat (2) step();
    rst = 1'b0;

    // Sample n is taken in the (n+1)-th cycle after release; the pulse belongs in the 64th.
    seen = 0; first_n = -1;
    for (int n = 0; n < 200 && !seen; n++) begin
      if (tx_valid_o) begin
        seen = 1;
        first_n = n;
        l = tx_ldata_o;
      end else begin
        step();
      end
    end
    check("post_rst_first_pulse", first_n, 32'd63);
    check("post_rst_word", {16'b0, l}, 32'h6969);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dop_sched.md
DOP_SCHED -- requirements
Module: dop_sched

Interface
REQ-001 Parameter DW, default 16: DSD payload bits per channel per DoP sample; the downstream serializer word width.
REQ-002 Parameter FIFO_DEPTH, default 4: payload FIFO entries, power of two.
REQ-003 Parameter LOCK_CNT, default 4: consecutive correctly alternating markers required for lock.
REQ-004 Parameter SLOT, default 64 (DW*4): bclk cycles per emitted word.
REQ-005 Port bclk, in, 1: single clock; all state on its rising edge.
REQ-006 Port rst, in, 1: asynchronous, active-high reset.
REQ-007 Port pcm_valid_i, in, 1: DoP PCM sample pair valid.
REQ-008 Port pcm_ready_o, out, 1: sample accepted when valid and ready are both high.
REQ-009 Port pcm_ldata_i / pcm_rdata_i, in, 24 each: [23:16] marker, [15:0] DSD payload.
REQ-010 Port tx_valid_o, out, 1: one-bclk load pulse to the serializer.
REQ-011 Port tx_ldata_o / tx_rdata_o, out, DW each: word to load, stable whenever tx_valid_o is high.
REQ-012 Port dop_lock_o, out, 1: marker lock status.
REQ-013 Ports underrun_o and marker_err_o, out, 1 each: one-cycle event pulses.

Function
REQ-014 Accept = pcm_valid_i & pcm_ready_o; pcm_ready_o SHALL be 1 in SEARCH and ~fifo_full in LOCKED; a read in the same cycle SHALL NOT unblock a full-FIFO write.
REQ-015 Marker FSM states: SEARCH, LOCKED; a sample's marker is good only if L[23:16]==R[23:16] and equals 8'h05 or 8'hFA.
REQ-016 SEARCH: the first good marker sets the expected next marker to the other value and sets run count 1; each further accepted good, correctly alternating marker increments the count; any other accepted sample sets count 0 and pulses marker_err_o.
REQ-017 SEARCH -> LOCKED in the cycle the count reaches LOCK_CNT; that sample's payload SHALL be written to the FIFO; earlier SEARCH samples SHALL be discarded.
REQ-018 LOCKED: each accepted correctly alternating sample writes {L[15:0], R[15:0]} to the FIFO; a wrong marker pulses marker_err_o, flushes the FIFO, clears lock and returns to SEARCH with count 0.
REQ-019 dop_lock_o SHALL be 1 exactly while the state is LOCKED.
REQ-020 Slot counter SHALL free-run 0..SLOT-1 and wrap; tx_valid_o SHALL pulse in every cycle where the count equals SLOT-1; first pulse in cycle SLOT after reset release.
REQ-021 Scheduler states: PRIME, RUN; PRIME -> RUN at a slot pulse when LOCKED and FIFO occupancy >= 2, popping one entry at that pulse.
REQ-022 In RUN each slot pulse SHALL pop one entry onto tx_ldata_o/tx_rdata_o; if the FIFO is empty, output {DW/8{8'h69}} on both channels, pulse underrun_o in the same cycle and go to PRIME.
REQ-023 In PRIME, and on any loss of lock (RUN -> PRIME immediately), words SHALL be DSD silence {DW/8{8'h69}}.
REQ-024 A FIFO write and pop in the same cycle SHALL both succeed when not full; a flush in the same cycle as a write or pop SHALL take priority.

Reset
REQ-025 While rst is high: state SEARCH/PRIME, counts 0, FIFO empty, tx_valid_o 0, underrun_o 0, marker_err_o 0, dop_lock_o 0, pcm_ready_o 1, tx_ldata_o/tx_rdata_o = 16'h6969.
REQ-026 Reset asserted mid-operation SHALL discard FIFO contents, with no tx_valid_o pulse until SLOT cycles after release.

Structure
REQ-027 Package dop_pkg SHALL hold the marker constants 8'h05/8'hFA, the silence byte 8'h69, and both state enums.
REQ-028 The FIFO SHALL be one sub-module, dop_fifo (synchronous, with flush, full/empty/count); everything else stays in dop_sched.

Verification
REQ-029 4 samples with markers 05,FA,05,FA -> dop_lock_o rises on the 4th acceptance; FIFO count 1.
REQ-030 Locked stream with payloads L=1234,R=ABCD then L=5678,R=EF01 -> tx words 1234/ABCD, then 5678/EF01, 64 cycles apart.
REQ-031 Locked, feed stops -> after the last word, next slot yields 6969/6969, underrun_o one pulse, scheduler PRIME.
REQ-032 Locked with 3 entries, sample with marker 05 where FA expected -> marker_err_o pulse, lock 0, FIFO empty, next words 6969.
REQ-033 FIFO full, valid held high -> pcm_ready_o 0; at the slot pop, ready returns 1 on the next cycle, no data lost.
REQ-034 rst asserted at slot count 30 while RUN -> all outputs at reset values; first tx_valid_o exactly 64 cycles after release.
